// File: rtl/spi_slave_sync.sv
`default_nettype none
// =============================================================================
// Module   : spi_slave_sync
// Brief    : Oversampled SPI slave (CPOL/CPHA, width, bit order) with RX/TX
//            valid/ready streams. Define SPI_SLAVE_RX_FIFO_EN for an RX FIFO.
// Revision : 1.0
// =============================================================================
module spi_slave_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_spi_sck,
  input  logic                  i_spi_mosi,
  input  logic                  i_spi_cs,
  output logic                  o_spi_miso,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  output logic                  o_overrun,
  output logic                  o_underrun,
  output logic                  o_busy
);

  localparam int         CW         = $clog2(DATA_WIDTH);
  localparam logic [0:0] c_IDLE     = 1'b0;
  localparam logic [0:0] c_ACTIVE   = 1'b1;
  localparam logic       c_SCK_IDLE = (CPOL != 0);

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sck_d, r_cs_d;
  logic                   w_sck, w_cs, w_mosi;
  logic                   w_rise, w_fall, w_lead, w_trail, w_sample, w_shift, w_cs_fall;

  // Chains reset to the idle pin levels so reset release never fakes an edge
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_sck_sync  <= {SYNC_STAGES{c_SCK_IDLE}};
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= c_SCK_IDLE;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs;
    end
  end

  assign w_sck     = r_sck_sync[SYNC_STAGES-1];
  assign w_cs      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    = w_sck & ~r_sck_d;
  assign w_fall    = ~w_sck & r_sck_d;
  assign w_lead    = c_SCK_IDLE ? w_fall : w_rise;
  assign w_trail   = c_SCK_IDLE ? w_rise : w_fall;
  assign w_sample  = (CPHA != 0) ? w_trail : w_lead;
  assign w_shift   = (CPHA != 0) ? w_lead : w_trail;
  assign w_cs_fall = r_cs_d & ~w_cs;

  logic [0:0]            r_state;
  logic [CW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_tx_shift, r_rx_shift, r_hold;
  logic [DATA_WIDTH-1:0] w_tx_next, w_rx_next;
  logic                  r_hold_full, r_skip, r_done, r_underrun;
  logic                  w_active, w_run, w_load, w_tx_wr, w_tx_bit;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign w_tx_bit  = r_tx_shift[DATA_WIDTH-1];
      assign w_tx_next = {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
      assign w_rx_next = {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
    end else begin : g_lsb
      assign w_tx_bit  = r_tx_shift[0];
      assign w_tx_next = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
      assign w_rx_next = {w_mosi, r_rx_shift[DATA_WIDTH-1:1]};
    end
  endgenerate

  assign w_active = (r_state == c_ACTIVE);
  assign w_run    = w_active & ~w_cs;
  assign w_load   = (~w_active & w_cs_fall) | (w_run & r_done);
  assign w_tx_wr  = i_tx_valid & ~r_hold_full;

  // r_skip swallows the first shift edge after a load: for CPHA=1 that is the
  // first leading edge; for CPHA=0 it is the trailing edge of the word just ended.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= c_IDLE;
      r_bit_cnt   <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_skip      <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      if (w_tx_wr && !w_load) begin
        r_hold      <= i_tx_data;
        r_hold_full <= 1'b1;
      end
      if (w_load) begin
        r_skip <= (CPHA != 0) || w_active;
        if (r_hold_full) begin
          r_tx_shift  <= r_hold;
          r_hold_full <= 1'b0;
        end else if (i_tx_valid) begin
          r_tx_shift <= i_tx_data;
        end else begin
          r_tx_shift <= '0;
          r_underrun <= 1'b1;
        end
      end else if (w_run && w_shift) begin
        if (r_skip) r_skip <= 1'b0;
        else        r_tx_shift <= w_tx_next;
      end
      if (w_run && w_sample) begin
        r_rx_shift <= w_rx_next;
        if (r_bit_cnt == CW'(DATA_WIDTH - 1)) begin
          r_bit_cnt <= '0;
          r_done    <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + CW'(1);
        end
      end
      if (!w_active && w_cs_fall) begin
        r_state   <= c_ACTIVE;
        r_bit_cnt <= '0;
      end else if (w_active && w_cs) begin
        r_state <= c_IDLE;
      end
    end
  end

  assign o_spi_miso = w_active & w_tx_bit;
  assign o_tx_ready = ~r_hold_full;
  assign o_underrun = r_underrun;
  assign o_busy     = w_active;

  logic r_overrun;
  logic w_accept;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [AW:0]           r_wr_ptr, r_rd_ptr, w_count;
  logic                  w_full, w_empty, w_push;

  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty  = (w_count == '0);
  assign w_accept = ~w_empty & i_rx_ready;
  assign w_push   = r_done & (~w_full | w_accept);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_done & ~w_push;
      if (w_push) begin
        r_fifo[r_wr_ptr[AW-1:0]] <= r_rx_shift;
        r_wr_ptr                 <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_accept) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  assign o_rx_data  = r_fifo[r_rd_ptr[AW-1:0]];
  assign o_rx_valid = ~w_empty;
`else
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  w_unused_cfg;

  assign w_accept     = r_rx_valid & i_rx_ready;
  assign w_unused_cfg = (FIFO_DEPTH > 0);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done) begin
        if (!r_rx_valid || w_accept) begin
          r_rx_data  <= r_rx_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
`endif

  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
`default_nettype none
// Bench for spi_slave_sync: instance m uses CPOL=m/2, CPHA=m%2, MSB first for m<2.
module tb_spi_slave_sync;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] sck, cs, tx_valid, rx_ready;
  logic       mosi;
  logic [7:0] tx_data [4];
  wire  [3:0] miso, tx_ready, rx_valid, ovr, und, busy;
  wire  [7:0] rx_data [4];
  int         ovr_cnt [4];
  int         und_cnt [4];
  int         total = 0;
  int         bad   = 0;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int EXP_B2B_OVR = 0;
`else
  localparam int EXP_B2B_OVR = 1;
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    spi_slave_sync #(
      .DATA_WIDTH(8), .CPOL(gi / 2), .CPHA(gi % 2), .MSB_FIRST(gi < 2 ? 1 : 0),
      .SYNC_STAGES(2), .FIFO_DEPTH(4)
    ) u_dut (
      .clk(clk), .i_rst(rst),
      .i_spi_sck(sck[gi]), .i_spi_mosi(mosi), .i_spi_cs(cs[gi]), .o_spi_miso(miso[gi]),
      .i_tx_data(tx_data[gi]), .i_tx_valid(tx_valid[gi]), .o_tx_ready(tx_ready[gi]),
      .o_rx_data(rx_data[gi]), .o_rx_valid(rx_valid[gi]), .i_rx_ready(rx_ready[gi]),
      .o_overrun(ovr[gi]), .o_underrun(und[gi]), .o_busy(busy[gi])
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ovr[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
      if (und[i]) und_cnt[i] <= und_cnt[i] + 1;
    end
  end

  // SCK half period = 4 clk (SCK = clk/8)
  task automatic half_bit();
    repeat (4) @(negedge clk);
  endtask

  task automatic load_tx(input int m, input logic [7:0] d);
    @(negedge clk);
    tx_data[m]  = d;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
  endtask

  task automatic accept(input int m);
    @(negedge clk);
    rx_ready[m] = 1'b1;
    @(negedge clk);
    rx_ready[m] = 1'b0;
  endtask

  task automatic drain(input int m);
    for (int k = 0; k < 8; k++) if (rx_valid[m]) accept(m);
  endtask

  task automatic xfer(input int m, input logic [7:0] dout, input int nbits,
                      input bit raise_cs, output logic [7:0] din);
    bit pol, pha, msb;
    int idx;
    pol = (m / 2) == 1;
    pha = (m % 2) == 1;
    msb = (m < 2);
    din = 8'h00;
    if (cs[m]) begin
      cs[m] = 1'b0;
      half_bit();
    end
    for (int b = 0; b < nbits; b++) begin
      idx = msb ? 7 - b : b;
      if (!pha) begin
        mosi = dout[idx];
        half_bit();
        if (msb) din = {din[6:0], miso[m]}; else din[b] = miso[m];
        sck[m] = ~pol;
        half_bit();
        sck[m] = pol;
      end else begin
        sck[m] = ~pol;
        mosi   = dout[idx];
        half_bit();
        if (msb) din = {din[6:0], miso[m]}; else din[b] = miso[m];
        sck[m] = pol;
        half_bit();
      end
    end
    if (!pha) half_bit();
    if (raise_cs) begin
      cs[m] = 1'b1;
      half_bit();
      half_bit();
    end
  endtask

  task automatic test_reset();
    for (int m = 0; m < 4; m++) begin
      total++;
      if ({miso[m], tx_ready[m], rx_valid[m], ovr[m], und[m], busy[m], rx_data[m]} !== 14'b01_0000_0000_0000) begin
        bad++;
        $display("FAIL reset_outputs[%0d]: got miso=%b rdy=%b rxv=%b ovr=%b und=%b busy=%b rx=%h, expected rdy=1 rest 0",
                 m, miso[m], tx_ready[m], rx_valid[m], ovr[m], und[m], busy[m], rx_data[m]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 4'b0000) begin bad++; $display("FAIL idle_busy: got %b expected 0000", busy); end
  endtask

  task automatic test_mode0();
    logic [7:0] d;
    load_tx(0, 8'hA5);
    total++;
    if (tx_ready[0] !== 1'b0) begin bad++; $display("FAIL m0_hold_full: got %b expected 0", tx_ready[0]); end
    xfer(0, 8'h3C, 8, 1'b1, d);
    total++;
    if (d !== 8'hA5) begin bad++; $display("FAIL m0_miso: got %h expected a5", d); end
    total++;
    if (rx_data[0] !== 8'h3C) begin bad++; $display("FAIL m0_rx_data: got %h expected 3c", rx_data[0]); end
    total++;
    if (rx_valid[0] !== 1'b1) begin bad++; $display("FAIL m0_rx_valid: got %b expected 1", rx_valid[0]); end
    total++;
    if (tx_ready[0] !== 1'b1) begin bad++; $display("FAIL m0_tx_ready: got %b expected 1", tx_ready[0]); end
    accept(0);
    total++;
    if (rx_valid[0] !== 1'b0) begin bad++; $display("FAIL m0_accept: got %b expected 0", rx_valid[0]); end
  endtask

  task automatic test_modes();
    logic [7:0] d;
    logic [7:0] words [4];
    words[1] = 8'h81;
    words[2] = 8'h0F;
    words[3] = 8'h81;
    for (int m = 1; m < 4; m++) begin
      load_tx(m, 8'h5A);
      xfer(m, words[m], 8, 1'b1, d);
      total++;
      if (rx_data[m] !== words[m] || rx_valid[m] !== 1'b1) begin
        bad++;
        $display("FAIL mode%0d_rx: got data=%h valid=%b expected data=%h valid=1", m, rx_data[m], rx_valid[m], words[m]);
      end
      total++;
      if (d !== 8'h5A) begin bad++; $display("FAIL mode%0d_miso: got %h expected 5a", m, d); end
      accept(m);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2;
    int o0, u0;
    load_tx(0, 8'h99);
    o0 = ovr_cnt[0];
    u0 = und_cnt[0];
    xfer(0, 8'h11, 8, 1'b0, d1);
    total++;
    if (und_cnt[0] - u0 !== 1) begin bad++; $display("FAIL b2b_underrun: got %0d expected 1", und_cnt[0] - u0); end
    xfer(0, 8'h22, 8, 1'b1, d2);
    total++;
    if (d1 !== 8'h99) begin bad++; $display("FAIL b2b_miso1: got %h expected 99", d1); end
    total++;
    if (d2 !== 8'h00) begin bad++; $display("FAIL b2b_miso2: got %h expected 00", d2); end
    total++;
    if (rx_data[0] !== 8'h11 || rx_valid[0] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_rx_kept: got data=%h valid=%b expected data=11 valid=1", rx_data[0], rx_valid[0]);
    end
    total++;
    if (ovr_cnt[0] - o0 !== EXP_B2B_OVR) begin
      bad++;
      $display("FAIL b2b_overrun: got %0d expected %0d", ovr_cnt[0] - o0, EXP_B2B_OVR);
    end
    drain(0);
  endtask

  task automatic test_abort();
    logic [7:0] d;
    int u0;
    u0 = und_cnt[0];
    xfer(0, 8'hFF, 5, 1'b1, d);
    total++;
    if (rx_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_partial: got valid=%b busy=%b expected 0 0", rx_valid[0], busy[0]);
    end
    total++;
    if (und_cnt[0] - u0 !== 1) begin bad++; $display("FAIL abort_underrun: got %0d expected 1", und_cnt[0] - u0); end
    load_tx(0, 8'hE1);
    xfer(0, 8'h77, 8, 1'b1, d);
    total++;
    if (rx_data[0] !== 8'h77 || rx_valid[0] !== 1'b1) begin
      bad++;
      $display("FAIL abort_realign: got data=%h valid=%b expected data=77 valid=1", rx_data[0], rx_valid[0]);
    end
    total++;
    if (d !== 8'hE1) begin bad++; $display("FAIL abort_miso: got %h expected e1", d); end
    accept(0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    xfer(0, 8'hAA, 4, 1'b0, d);
    load_tx(0, 8'h3C);
    total++;
    if (busy[0] !== 1'b1 || tx_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL midword_state: got busy=%b rdy=%b expected 1 0", busy[0], tx_ready[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({miso[0], tx_ready[0], rx_valid[0], ovr[0], und[0], busy[0], rx_data[0]} !== 14'b01_0000_0000_0000) begin
      bad++;
      $display("FAIL async_reset: got miso=%b rdy=%b rxv=%b ovr=%b und=%b busy=%b rx=%h, expected rdy=1 rest 0",
               miso[0], tx_ready[0], rx_valid[0], ovr[0], und[0], busy[0], rx_data[0]);
    end
    cs[0]  = 1'b1;
    sck[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    load_tx(0, 8'h96);
    xfer(0, 8'hC3, 8, 1'b1, d);
    total++;
    if (rx_data[0] !== 8'hC3 || rx_valid[0] !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_rx: got data=%h valid=%b expected data=c3 valid=1", rx_data[0], rx_valid[0]);
    end
    total++;
    if (d !== 8'h96) begin bad++; $display("FAIL post_reset_miso: got %h expected 96", d); end
    accept(0);
  endtask

`ifdef SPI_SLAVE_RX_FIFO_EN
  task automatic test_fifo();
    logic [7:0] d;
    int o0;
    drain(0);
    o0 = ovr_cnt[0];
    for (int k = 1; k <= 5; k++) xfer(0, 8'(k), 8, 1'b1, d);
    total++;
    if (ovr_cnt[0] - o0 !== 1) begin bad++; $display("FAIL fifo_overrun: got %0d expected 1", ovr_cnt[0] - o0); end
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (rx_valid[0] !== 1'b1 || rx_data[0] !== 8'(k)) begin
        bad++;
        $display("FAIL fifo_entry%0d: got data=%h valid=%b expected data=%h valid=1", k, rx_data[0], rx_valid[0], 8'(k));
      end
      accept(0);
    end
    total++;
    if (rx_valid[0] !== 1'b0) begin bad++; $display("FAIL fifo_empty: got %b expected 0", rx_valid[0]); end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    sck      = 4'b1100;
    cs       = 4'b1111;
    mosi     = 1'b0;
    tx_valid = 4'b0000;
    rx_ready = 4'b0000;
    for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef SPI_SLAVE_RX_FIFO_EN
    test_fifo();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
